// File: rtl/bsearch_guesser_if.sv
// Compare-channel bundle between the guess engine (master) and a magnitude-comparator responder (slave).
// The master presents guess/guess_valid; the slave answers with res_valid and one-hot aeqb/agtb/altb.
interface bsearch_guesser_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             res_valid;
  logic             aeqb;
  logic             agtb;
  logic             altb;

  modport master (
    output guess,
    output guess_valid,
    input  res_valid,
    input  aeqb,
    input  agtb,
    input  altb
  );

  modport slave (
    input  guess,
    input  guess_valid,
    output res_valid,
    output aeqb,
    output agtb,
    output altb
  );
endinterface

// File: rtl/bsearch_guesser.sv
// bsearch_guesser: binary-search guess engine opposite a magnitude comparator; GUESS_LIMIT_EN adds a try budget and limit_hit.
// Latency: first guess 1 cycle after start, next guess 2 cycles after each accepted response.
// Backpressure: guess is held with guess_valid high until res_valid accepts it.
module bsearch_guesser #(
  parameter int WIDTH     = 7,
  parameter int MAX_TRIES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  bsearch_guesser_if.master cmp,
  output logic             done,
  output logic             found,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       tries
`ifdef GUESS_LIMIT_EN
  ,
  output logic             limit_hit
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GUESS  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [WIDTH:0]   TOP  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] GMAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MID0 = WIDTH'(TOP >> 1);

`ifdef GUESS_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic [1:0]       state;
  logic [WIDTH:0]   lo;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] guess;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] mid;
  logic [WIDTH:0]   guess_ext;
  logic [2:0]       flags;
  logic             accept;
  logic             is_eq;
  logic             is_gt;
  logic             is_lt;
  logic             bad;
  logic             limit_stop;
  logic [3:0]       tries_nxt;
  logic             restart;

  // Bounds are one bit wider so lo=hi+1 (empty interval) is representable.
  assign sum        = lo + hi;
  assign mid        = WIDTH'(sum >> 1);
  assign guess_ext  = {1'b0, guess};
  assign flags      = {cmp.aeqb, cmp.agtb, cmp.altb};
  assign accept     = (state == S_GUESS) && cmp.res_valid;
  assign is_eq      = (flags == 3'b100);
  assign is_gt      = (flags == 3'b010);
  assign is_lt      = (flags == 3'b001);
  assign bad        = !(is_eq || is_gt || is_lt) ||
                      (is_gt && (guess == GMAX)) ||
                      (is_lt && (guess == '0));
  assign tries_nxt  = tries + 4'd1;
  assign limit_stop = LIMIT_EN && (is_gt || is_lt) && !bad &&
                      (tries_nxt == 4'(MAX_TRIES));
  assign restart    = start && ((state == S_IDLE) || (state == S_DONE));

  assign cmp.guess       = guess;
  assign cmp.guess_valid = (state == S_GUESS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      lo     <= '0;
      hi     <= TOP;
      guess  <= '0;
      done   <= 1'b0;
      found  <= 1'b0;
      error  <= 1'b0;
      result <= '0;
      tries  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (restart) begin
            lo     <= '0;
            hi     <= TOP;
            guess  <= MID0;
            tries  <= '0;
            done   <= 1'b0;
            found  <= 1'b0;
            error  <= 1'b0;
            result <= '0;
            state  <= S_GUESS;
          end
        end
        S_GUESS: begin
          if (accept) begin
            tries <= tries_nxt;
            if (is_eq) begin
              result <= guess;
              found  <= 1'b1;
              done   <= 1'b1;
              state  <= S_DONE;
            end else if (bad) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              if (is_gt) lo <= guess_ext + ONE;
              else       hi <= guess_ext - ONE;
              if (limit_stop) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                state <= S_UPDATE;
              end
            end
          end
        end
        S_UPDATE: begin
          // A liar can pinch the interval shut; that is the only inconsistency caught here.
          if (lo > hi) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            guess <= mid;
            state <= S_GUESS;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef GUESS_LIMIT_EN
  always_ff @(posedge clock) begin
    if (reset)                     limit_hit <= 1'b0;
    else if (restart)              limit_hit <= 1'b0;
    else if (accept && limit_stop) limit_hit <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_bsearch_guesser.sv
// Randomized bench for bsearch_guesser: a responder plus an interval model predicts every guess and the final outcome.
module tb_bsearch_guesser;

`ifdef GUESS_LIMIT_EN
  localparam bit LIM_EN = 1'b1;
  localparam int MAXT   = 4;
`else
  localparam bit LIM_EN = 1'b0;
  localparam int MAXT   = 8;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic       found;
  logic       error;
  logic [6:0] result;
  logic [3:0] tries;
`ifdef GUESS_LIMIT_EN
  logic       limit_hit;
`endif

  int vectors     = 0;
  int miscompares = 0;

  bsearch_guesser_if #(.WIDTH(7)) cmp ();

  bsearch_guesser #(.WIDTH(7), .MAX_TRIES(MAXT)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .cmp       (cmp),
    .done      (done),
    .found     (found),
    .error     (error),
    .result    (result),
    .tries     (tries)
`ifdef GUESS_LIMIT_EN
    ,
    .limit_hit (limit_hit)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gv"},     cmp.guess_valid, 0);
    check({tag, "_guess"},  cmp.guess, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_found"},  found, 0);
    check({tag, "_error"},  error, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_tries"},  tries, 0);
`ifdef GUESS_LIMIT_EN
    check({tag, "_limit"},  limit_hit, 0);
`endif
  endtask

  // Modes: 0 honest, 1 always altb, 2 always agtb, 3 random flags, 4 random one-hot lies, 5 aeqb+agtb.
  task automatic run_search(input int mode, input int secret, input int stall_fix);
    int lo, hi, g, n, stalls;
    bit fin, exp_found, exp_err, exp_lim;
    logic [2:0] f;
    lo = 0; hi = 127; n = 0; g = 0;
    fin = 0; exp_found = 0; exp_err = 0; exp_lim = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!fin) begin
      g = (lo + hi) / 2;
      check("guess_valid", cmp.guess_valid, 1);
      check("guess", cmp.guess, g);
      check("busy_done", done, 0);
      stalls = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
      for (int s = 0; s < stalls; s++) begin
        cmp.res_valid = 1'b0;
        {cmp.aeqb, cmp.agtb, cmp.altb} = 3'($urandom);
        start = ($urandom_range(0, 3) == 0);
        @(negedge clock);
        start = 1'b0;
        check("stall_guess", cmp.guess, g);
        check("stall_valid", cmp.guess_valid, 1);
      end
      case (mode)
        0:       f = (secret == g) ? 3'b100 : (secret > g) ? 3'b010 : 3'b001;
        1:       f = 3'b001;
        2:       f = 3'b010;
        3:       f = 3'($urandom);
        4:       f = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'b001;
        default: f = 3'b110;
      endcase
      cmp.res_valid = 1'b1;
      {cmp.aeqb, cmp.agtb, cmp.altb} = f;
      @(negedge clock);
      n++;
      cmp.res_valid = ($urandom_range(0, 1) != 0);
      {cmp.aeqb, cmp.agtb, cmp.altb} = 3'($urandom);
      if (f == 3'b100) begin
        fin = 1; exp_found = 1;
      end else if ((f == 3'b010 && g != 127) || (f == 3'b001 && g != 0)) begin
        if (f == 3'b010) lo = g + 1;
        else             hi = g - 1;
        if (LIM_EN && n == MAXT) begin
          fin = 1; exp_lim = 1;
        end else begin
          check("bubble_gv", cmp.guess_valid, 0);
          check("bubble_done", done, 0);
          @(negedge clock);
          cmp.res_valid = 1'b0;
          if (lo > hi) begin
            fin = 1; exp_err = 1;
          end
        end
      end else begin
        fin = 1; exp_err = 1;
      end
      if (!fin && n >= 20) begin
        check("runaway_tries", n, 0);
        fin = 1;
      end
    end
    check("end_done",   done, 1);
    check("end_found",  found, exp_found);
    check("end_error",  error, exp_err);
    check("end_result", result, exp_found ? g : 0);
    check("end_tries",  tries, n);
    check("end_gv",     cmp.guess_valid, 0);
`ifdef GUESS_LIMIT_EN
    check("end_limit",  limit_hit, exp_lim);
`endif
    for (int k = 0; k < 2; k++) begin
      cmp.res_valid = ($urandom_range(0, 1) != 0);
      {cmp.aeqb, cmp.agtb, cmp.altb} = 3'($urandom);
      @(negedge clock);
      check("hold_done",  done, 1);
      check("hold_tries", tries, n);
      check("hold_found", found, exp_found);
    end
    cmp.res_valid = 1'b0;
  endtask

  // Reset lands during the third guess while a response is being offered.
  task automatic reset_test();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cmp.res_valid = 1'b1;
      {cmp.aeqb, cmp.agtb, cmp.altb} = 3'b010;
      @(negedge clock);
      cmp.res_valid = 1'b0;
      @(negedge clock);
    end
    check("rst_pre_guess", cmp.guess, 111);
    cmp.res_valid = 1'b1;
    {cmp.aeqb, cmp.agtb, cmp.altb} = 3'b010;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values("midrst");
    @(negedge clock);
    check_reset_values("postrst");
    cmp.res_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cmp.res_valid = 1'b0;
    {cmp.aeqb, cmp.agtb, cmp.altb} = 3'b000;
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clock);
    check_reset_values("idle");

    run_search(0, 63, -1);
    run_search(0, 127, -1);
    run_search(0, 0, -1);
    run_search(1, 0, -1);
    run_search(5, 0, -1);
    reset_test();
    run_search(0, 100, -1);
    run_search(0, int'($urandom_range(0, 127)), 5);
    for (int i = 0; i < 40; i++)
      run_search(int'($urandom_range(0, 4)), int'($urandom_range(0, 127)), -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

endmodule
